// File: rtl/bucket_writer_if.sv
// bucket_writer_if: update-request handshake into bucket_writer.
//   in_valid/in_ready : valid/ready handshake
//   in_op             : 00 INC, 01 SET, 10 CLR, 11 CLR_ALL
//   in_index          : bucket select, bit k selects bucket k
//   in_value          : operand for INC and SET
interface bucket_writer_if #(
  parameter int NUM_BUCKETS = 12,
  parameter int BUCKET_SZ   = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_op;
  logic [NUM_BUCKETS-1:0] in_index;
  logic [BUCKET_SZ-1:0]   in_value;
  modport master (output in_valid, in_op, in_index, in_value, input in_ready);
  modport slave  (input in_valid, in_op, in_index, in_value, output in_ready);
endinterface

// File: rtl/bucket_writer.sv
// bucket_writer: owns a packed word of small counters, applies update requests and ages it.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : update request handshake (bucket_writer_if.slave)
//   age          : single-cycle aging pulse
//   data_out     : packed bucket word, top bucket in the MSBs, zero padding below
//   data_valid   : pulse when data_out changes
//   sat_event    : pulse when an INC saturated
//   err_index    : pulse when an INC/SET index was not one-hot
//   expired      : pulse when aging shifted out a nonzero bucket 0
//   age_drop     : pulse when an age pulse was lost to a full pending counter
module bucket_writer #(
  parameter int DATA_WIDTH  = 72,
  parameter int NUM_BUCKETS = 12,
  parameter int BUCKET_SZ   = 4,
  parameter int AGE_CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bucket_writer_if.slave        req,
  input  logic                  age,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  sat_event,
  output logic                  err_index,
  output logic                  expired,
  output logic                  age_drop
);
  localparam int BW  = NUM_BUCKETS * BUCKET_SZ;
  localparam int PAD = DATA_WIDTH - BW;
  localparam logic [1:0] OP_INC = 2'b00, OP_SET = 2'b01, OP_CLR_ALL = 2'b11;
  typedef enum logic [1:0] {IDLE, EXEC, AGE} state_t;
  state_t                 state_q, state_d;
  logic [BW-1:0]          data_q, data_d, wr_data;
  logic [AGE_CNT_W-1:0]   age_cnt_q, age_cnt_d;
  logic [1:0]             op_q, op_d;
  logic [NUM_BUCKETS-1:0] index_q, index_d;
  logic [BUCKET_SZ-1:0]   value_q, value_d, sel_val, upd_val;
  logic [BUCKET_SZ:0]     sum;
  logic                   dv_q, dv_d, sat_q, sat_d, err_q, err_d, exp_q, exp_d, drop_q, drop_d;
  logic                   legal, one_hot, dec, accept;
  assign req.in_ready = (state_q == IDLE) && (age_cnt_q == '0) && !age;
  assign accept       = req.in_valid && req.in_ready;
  assign data_out     = DATA_WIDTH'(data_q) << PAD;
  assign data_valid   = dv_q;
  assign sat_event    = sat_q;
  assign err_index    = err_q;
  assign expired      = exp_q;
  assign age_drop     = drop_q;
  assign one_hot      = (index_q != '0) && ((index_q & (index_q - 1'b1)) == '0);
  assign legal        = op_q[1] || one_hot;
  // A pending age is consumed by every AGE cycle; a simultaneous new pulse cancels it out.
  assign dec          = (state_q == AGE);
  assign age_cnt_d    = (age && !dec) ? ((age_cnt_q == '1) ? age_cnt_q : age_cnt_q + 1'b1) :
                        (dec && !age) ? age_cnt_q - 1'b1 : age_cnt_q;
  assign drop_d       = age && !dec && (age_cnt_q == '1);
  assign op_d         = accept ? req.in_op : op_q;
  assign index_d      = accept ? req.in_index : index_q;
  assign value_d      = accept ? req.in_value : value_q;
  // Merged update for INC/SET/CLR; the INC sum is only meaningful when the index is one-hot.
  always_comb begin
    sel_val = '0;
    wr_data = data_q;
    for (int k = 0; k < NUM_BUCKETS; k++)
      sel_val = sel_val | ({BUCKET_SZ{index_q[k]}} & data_q[k*BUCKET_SZ +: BUCKET_SZ]);
    sum     = {1'b0, sel_val} + {1'b0, value_q};
    upd_val = (op_q == OP_INC) ? (sum[BUCKET_SZ] ? '1 : sum[BUCKET_SZ-1:0]) :
              (op_q == OP_SET) ? value_q : '0;
    for (int k = 0; k < NUM_BUCKETS; k++)
      if (index_q[k]) wr_data[k*BUCKET_SZ +: BUCKET_SZ] = upd_val;
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    sat_d   = 1'b0;
    err_d   = 1'b0;
    exp_d   = 1'b0;
    case (state_q)
      IDLE: state_d = (age_cnt_q != '0 || age) ? AGE : accept ? EXEC : IDLE;
      EXEC: begin
        data_d  = (op_q == OP_CLR_ALL) ? '0 : legal ? wr_data : data_q;
        dv_d    = legal;
        err_d   = !legal;
        sat_d   = legal && (op_q == OP_INC) && sum[BUCKET_SZ];
        state_d = (age_cnt_q != '0 || age) ? AGE : IDLE;
      end
      AGE: begin
        data_d  = data_q >> BUCKET_SZ;
        dv_d    = 1'b1;
        exp_d   = data_q[BUCKET_SZ-1:0] != '0;
        state_d = (age_cnt_d != '0) ? AGE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      age_cnt_q <= '0;
      op_q      <= '0;
      index_q   <= '0;
      value_q   <= '0;
      dv_q      <= 1'b0;
      sat_q     <= 1'b0;
      err_q     <= 1'b0;
      exp_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      age_cnt_q <= age_cnt_d;
      op_q      <= op_d;
      index_q   <= index_d;
      value_q   <= value_d;
      dv_q      <= dv_d;
      sat_q     <= sat_d;
      err_q     <= err_d;
      exp_q     <= exp_d;
      drop_q    <= drop_d;
    end
endmodule

// File: tb/tb_bucket_writer.sv
// tb_bucket_writer: randomized bench for bucket_writer against a bucket-array reference model.
module tb_bucket_writer;
  localparam int DW = 72, NB = 12, BS = 4, AW = 4;
  localparam int BMAX = (1 << BS) - 1, AMAX = (1 << AW) - 1;
  localparam logic [1:0] INC = 2'b00, SET = 2'b01, CLR = 2'b10, CLR_ALL = 2'b11;
  logic clk = 1'b0, reset_n = 1'b0, age = 1'b0;
  logic [DW-1:0] data_out;
  logic data_valid, sat_event, err_index, expired, age_drop;
  bucket_writer_if #(.NUM_BUCKETS(NB), .BUCKET_SZ(BS)) bif();
  bucket_writer #(.DATA_WIDTH(DW), .NUM_BUCKETS(NB), .BUCKET_SZ(BS), .AGE_CNT_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .req(bif.slave), .age(age), .data_out(data_out),
    .data_valid(data_valid), .sat_event(sat_event), .err_index(err_index),
    .expired(expired), .age_drop(age_drop));
  always #5 clk = ~clk;
  int n_vec = 0, n_bad = 0;
  int b[NB];
  int pend;
  bit req_pend, aging;
  logic [1:0] r_op;
  logic [NB-1:0] r_idx;
  int r_val;
  bit e_dv, e_sat, e_err, e_exp, e_drop;
  task automatic check(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [DW-1:0] pack();
    logic [DW-1:0] w = '0;
    for (int k = 0; k < NB; k++) w[DW-1-(NB-1-k)*BS -: BS] = b[k][BS-1:0];
    return w;
  endfunction
  task automatic model_reset();
    foreach (b[k]) b[k] = 0;
    pend = 0; req_pend = 0; aging = 0;
    {e_dv, e_sat, e_err, e_exp, e_drop} = '0;
  endtask
  function automatic bit m_ready(bit a);
    return !req_pend && !aging && pend == 0 && !a;
  endfunction
  task automatic add_age(bit a);
    if (a) begin
      if (pend == AMAX) e_drop = 1; else pend++;
    end
  endtask
  // Advances the model across one rising edge with the given inputs applied.
  task automatic model_edge(bit v, logic [1:0] op, logic [NB-1:0] idx, int val, bit a);
    bit rdy = m_ready(a);
    {e_dv, e_sat, e_err, e_exp, e_drop} = '0;
    if (req_pend) begin
      req_pend = 0;
      if (r_op == CLR_ALL) begin
        foreach (b[k]) b[k] = 0;
        e_dv = 1;
      end else if (r_op == CLR) begin
        foreach (b[k]) if (r_idx[k]) b[k] = 0;
        e_dv = 1;
      end else if ($countones(r_idx) != 1) e_err = 1;
      else begin
        foreach (b[k]) if (r_idx[k]) begin
          int s = (r_op == INC) ? b[k] + r_val : r_val;
          e_sat = s > BMAX;
          b[k] = (s > BMAX) ? BMAX : s;
        end
        e_dv = 1;
      end
      add_age(a);
      aging = pend > 0;
    end else if (aging) begin
      e_exp = b[0] != 0;
      for (int k = 0; k < NB - 1; k++) b[k] = b[k+1];
      b[NB-1] = 0;
      e_dv = 1;
      pend = pend - 1 + int'(a);
      aging = pend > 0;
    end else begin
      add_age(a);
      aging = pend > 0;
      if (!aging && v && rdy) begin
        req_pend = 1; r_op = op; r_idx = idx; r_val = val;
      end
    end
  endtask
  task automatic step(bit v, logic [1:0] op, logic [NB-1:0] idx, int val, bit a);
    @(negedge clk);
    bif.in_valid = v; bif.in_op = op; bif.in_index = idx; bif.in_value = val[BS-1:0]; age = a;
    #1 check("in_ready", DW'(bif.in_ready), DW'(m_ready(a)));
    model_edge(v, op, idx, val % (BMAX + 1), a);
    @(posedge clk);
    #1;
    check("data_out", data_out, pack());
    check("data_valid", DW'(data_valid), DW'(e_dv));
    check("sat_event", DW'(sat_event), DW'(e_sat));
    check("err_index", DW'(err_index), DW'(e_err));
    check("expired", DW'(expired), DW'(e_exp));
    check("age_drop", DW'(age_drop), DW'(e_drop));
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, INC, '0, 0, 0);
  endtask
  task automatic check_reset_outputs();
    check("rst_data_out", data_out, '0);
    check("rst_pulses", DW'({data_valid, sat_event, err_index, expired, age_drop}), '0);
    check("rst_in_ready", DW'(bif.in_ready), DW'(1));
  endtask
  initial begin
    bif.in_valid = 0; bif.in_op = '0; bif.in_index = '0; bif.in_value = '0;
    model_reset();
    #12 check_reset_outputs();
    @(negedge clk) reset_n = 1;
    step(1, INC, 12'h800, 3, 0); idle(2);
    step(1, SET, 12'h800, 14, 0); idle(1);
    step(1, INC, 12'h800, 5, 0); idle(2);
    step(1, CLR_ALL, 12'h000, 0, 0); idle(1);
    step(1, SET, 12'h400, 10, 0); idle(1);
    step(1, SET, 12'h800, 3, 0); idle(1);
    for (int i = 0; i < 12; i++) begin step(0, INC, '0, 0, 1); idle(1); end
    step(1, INC, 12'h800, 1, 0); step(0, INC, '0, 0, 1); idle(3);
    step(1, SET, 12'h800, 7, 0); idle(1);
    step(1, INC, 12'h003, 2, 0); idle(1);
    step(1, SET, 12'h000, 2, 0); idle(1);
    step(1, SET, 12'h400, 9, 0); idle(1);
    step(1, CLR, 12'hC00, 0, 0); idle(1);
    step(1, CLR, 12'h000, 0, 0); idle(1);
    for (int i = 0; i < 16; i++) step(i % 3 == 0, INC, 12'h800, 15, 1);
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 7);
      logic [NB-1:0] idx = (r == 0) ? NB'($urandom) : (r == 1) ? '0 : NB'(1) << $urandom_range(0, NB - 1);
      step(1'($urandom_range(0, 1)), 2'($urandom), idx, $urandom_range(0, BMAX), $urandom_range(0, 9) == 0);
      if (i == 1500) begin
        step(1, SET, 12'h001, 5, 0); step(0, INC, '0, 0, 1); step(0, INC, '0, 0, 1);
        bif.in_valid = 0; age = 0;
        #2 reset_n = 0;
        #1 check_reset_outputs();
        model_reset();
        @(negedge clk) reset_n = 1;
      end
    end
    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
